// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory copy engine: size codes, request
// sign-mask encodings, FSM states and per-size increment/alignment helpers.
package dm_pkg;

   typedef enum logic [1:0] {
      DM_SZ_BYTE = 2'b00,
      DM_SZ_HALF = 2'b01,
      DM_SZ_WORD = 2'b10,
      DM_SZ_ILL  = 2'b11
   } dm_size_e;

   // {sign, width code}; sign is always 0 for this initiator
   localparam logic [3:0] DM_SM_BYTE = 4'b0001;
   localparam logic [3:0] DM_SM_HALF = 4'b0011;
   localparam logic [3:0] DM_SM_WORD = 4'b0111;

   localparam logic [2:0] DM_INC_BYTE = 3'd1;
   localparam logic [2:0] DM_INC_HALF = 3'd2;
   localparam logic [2:0] DM_INC_WORD = 3'd4;

   localparam logic [1:0] DM_AMASK_BYTE = 2'b00;
   localparam logic [1:0] DM_AMASK_HALF = 2'b01;
   localparam logic [1:0] DM_AMASK_WORD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_CAP,
      ST_WR_REQ,
      ST_WR_WAIT,
      ST_DONE
   } dm_state_e;

   function automatic logic [2:0] dm_incr(input dm_size_e s);
      case (s)
         DM_SZ_BYTE: return DM_INC_BYTE;
         DM_SZ_HALF: return DM_INC_HALF;
         DM_SZ_WORD: return DM_INC_WORD;
         default:    return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] dm_amask(input dm_size_e s);
      case (s)
         DM_SZ_BYTE: return DM_AMASK_BYTE;
         DM_SZ_HALF: return DM_AMASK_HALF;
         DM_SZ_WORD: return DM_AMASK_WORD;
         default:    return 2'b11;
      endcase
   endfunction

   function automatic logic [3:0] dm_size_to_sm(input dm_size_e s);
      case (s)
         DM_SZ_BYTE: return DM_SM_BYTE;
         DM_SZ_HALF: return DM_SM_HALF;
         DM_SZ_WORD: return DM_SM_WORD;
         default:    return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] dm_elem_mask(input dm_size_e s);
      case (s)
         DM_SZ_BYTE: return 32'h0000_00FF;
         DM_SZ_HALF: return 32'h0000_FFFF;
         DM_SZ_WORD: return 32'hFFFF_FFFF;
         default:    return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/dm_copy_addr_ctr.sv
// Source/destination address and remaining-element counters for the copy
// engine; exposes next-cycle addresses so requests can be registered.
module dm_copy_addr_ctr
   import dm_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  dm_size_e          size,
   input  logic [ADDR_W-1:0] src_in,
   input  logic [ADDR_W-1:0] dst_in,
   input  logic [CNT_W-1:0]  count_in,
   output logic [ADDR_W-1:0] src_nxt,
   output logic [ADDR_W-1:0] dst_nxt,
   output logic              last
);

   logic [ADDR_W-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [CNT_W-1:0]  remaining;
   logic [CNT_W-1:0]  rem_nxt;
   logic [ADDR_W-1:0] incr;

   assign incr = ADDR_W'(dm_incr(size));
   assign last = (remaining == CNT_W'(1));

   // Addresses wrap naturally modulo 2^ADDR_W
   always_comb begin
      src_nxt = cur_src;
      dst_nxt = cur_dst;
      rem_nxt = remaining;
      if (load) begin
         src_nxt = src_in;
         dst_nxt = dst_in;
         rem_nxt = count_in;
      end else if (step) begin
         src_nxt = cur_src + incr;
         dst_nxt = cur_dst + incr;
         rem_nxt = remaining - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
      end else begin
         cur_src   <= src_nxt;
         cur_dst   <= dst_nxt;
         remaining <= rem_nxt;
      end
   end

endmodule

// File: rtl/dm_copy_engine.sv
// Data-memory copy/fill initiator issuing registered one-cycle read/write requests.
// Optional fill mode (fill, fill_data ports) enabled by defining DM_COPY_FILL_EN.
module dm_copy_engine
   import dm_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic [1:0]        size,
`ifdef DM_COPY_FILL_EN
   input  logic              fill,
   input  logic [31:0]       fill_data,
`endif
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_write_data,
   output logic              dm_memread,
   output logic              dm_memwrite,
   output logic [3:0]        dm_sign_mask,
   input  logic [31:0]       dm_read_data,
   input  logic              dm_clk_stall
);

   dm_state_e         state_q, state_d;
   dm_size_e          size_q, size_in, size_eff;
   logic [31:0]       data_q, data_d;
   logic              fill_q, fill_d;
   logic              fill_req;
   logic [31:0]       fill_word;
   logic              accept, bad, step, last;
   logic [1:0]        amask;
   logic [ADDR_W-1:0] src_nxt, dst_nxt;

   logic              busy_d, done_d, err_d, memread_d, memwrite_d;
   logic [ADDR_W-1:0] addr_d;
   logic [31:0]       wdata_d;
   logic [3:0]        smask_d;

`ifdef DM_COPY_FILL_EN
   assign fill_req  = fill;
   assign fill_word = fill_data;
`else
   assign fill_req  = 1'b0;
   assign fill_word = '0;
`endif

   assign accept   = (state_q == ST_IDLE) && start;
   assign size_in  = dm_size_e'(size);
   assign size_eff = accept ? size_in : size_q;
   assign amask    = dm_amask(size_in);
   assign step     = (state_q == ST_WR_WAIT) && !dm_clk_stall;

   // Source alignment is irrelevant when filling
   assign bad = (size_in == DM_SZ_ILL)
             || (((src_addr[1:0] & amask) != 2'b00) && !fill_req)
             || ((dst_addr[1:0] & amask) != 2'b00);

   dm_copy_addr_ctr #(
      .CNT_W (CNT_W),
      .ADDR_W(ADDR_W)
   ) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .step    (step),
      .size    (size_q),
      .src_in  (src_addr),
      .dst_in  (dst_addr),
      .count_in(count),
      .src_nxt (src_nxt),
      .dst_nxt (dst_nxt),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (bad || (count == '0)) state_d = ST_DONE;
               else if (fill_req)        state_d = ST_WR_REQ;
               else                      state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ:  state_d = ST_RD_CAP;
         ST_RD_CAP:  state_d = ST_WR_REQ;
         ST_WR_REQ:  state_d = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (!dm_clk_stall) begin
               if (last)        state_d = ST_DONE;
               else if (fill_q) state_d = ST_WR_REQ;
               else             state_d = ST_RD_REQ;
            end
         end
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Request outputs are derived from the next state so they are registered
   always_comb begin
      data_d = data_q;
      if (accept && fill_req)
         data_d = fill_word & dm_elem_mask(size_in);
      else if (state_q == ST_RD_CAP)
         data_d = dm_read_data & dm_elem_mask(size_q);

      fill_d     = accept ? fill_req : fill_q;
      err_d      = accept ? bad : err;
      memread_d  = (state_d == ST_RD_REQ);
      memwrite_d = (state_d == ST_WR_REQ);
      done_d     = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);

      addr_d  = dm_addr;
      wdata_d = dm_write_data;
      smask_d = dm_sign_mask;
      if (memread_d) begin
         addr_d  = src_nxt;
         smask_d = dm_size_to_sm(size_eff);
      end else if (memwrite_d) begin
         addr_d  = dst_nxt;
         wdata_d = data_d;
         smask_d = dm_size_to_sm(size_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         size_q        <= DM_SZ_BYTE;
         data_q        <= '0;
         fill_q        <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         dm_memread    <= 1'b0;
         dm_memwrite   <= 1'b0;
         dm_addr       <= '0;
         dm_write_data <= '0;
         dm_sign_mask  <= 4'b0000;
      end else begin
         state_q       <= state_d;
         size_q        <= size_eff;
         data_q        <= data_d;
         fill_q        <= fill_d;
         busy          <= busy_d;
         done          <= done_d;
         err           <= err_d;
         dm_memread    <= memread_d;
         dm_memwrite   <= memwrite_d;
         dm_addr       <= addr_d;
         dm_write_data <= wdata_d;
         dm_sign_mask  <= smask_d;
      end
   end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Self-checking bench for dm_copy_engine: byte-addressed memory model with a
// one-cycle write stall, request scoreboard and table-driven copy vectors.
module tb_dm_copy_engine;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] src_addr = '0;
   logic [ADDR_W-1:0] dst_addr = '0;
   logic [CNT_W-1:0]  count = '0;
   logic [1:0]        size = '0;
`ifdef DM_COPY_FILL_EN
   logic              fill = 1'b0;
   logic [31:0]       fill_data = '0;
`endif
   logic              busy, done, err;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_write_data;
   logic              dm_memread, dm_memwrite;
   logic [3:0]        dm_sign_mask;
   logic [31:0]       dm_read_data = '0;
   logic              dm_clk_stall = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;
   int n_reads = 0;
   int n_writes = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } txn_t;
   txn_t rd_q[$];
   txn_t wr_q[$];

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          cnt;
      logic [1:0]  size;
      bit          fill;
      logic [31:0] fdata;
      bit          exp_err;
      int          exp_lat;
      int          exp_reads;
   } vec_t;
   vec_t vecs[$];

   logic [7:0]  mem     [4096];
   logic [7:0]  ref_mem [4096];
   logic [31:0] mem_rd;

   dm_copy_engine #(
      .CNT_W (CNT_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .src_addr     (src_addr),
      .dst_addr     (dst_addr),
      .count        (count),
      .size         (size),
`ifdef DM_COPY_FILL_EN
      .fill         (fill),
      .fill_data    (fill_data),
`endif
      .busy         (busy),
      .done         (done),
      .err          (err),
      .dm_addr      (dm_addr),
      .dm_write_data(dm_write_data),
      .dm_memread   (dm_memread),
      .dm_memwrite  (dm_memwrite),
      .dm_sign_mask (dm_sign_mask),
      .dm_read_data (dm_read_data),
      .dm_clk_stall (dm_clk_stall)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [3:0] m);
      return m[2] ? 4 : (m[1] ? 2 : 1);
   endfunction

   function automatic logic [11:0] midx(input logic [31:0] a, input int j);
      logic [31:0] s;
      s = a + 32'(j);
      return s[11:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory: read data valid the cycle after memread (junk in unused lanes),
   // stall held for one cycle after every write.
   always @(posedge clk) begin
      dm_clk_stall <= dm_memwrite;
      mem_rd = $urandom;
      if (dm_memread)
         for (int j = 0; j < nbytes(dm_sign_mask); j++)
            mem_rd[8*j +: 8] = mem[midx(dm_addr, j)];
      dm_read_data <= mem_rd;
      if (dm_memwrite)
         for (int j = 0; j < nbytes(dm_sign_mask); j++)
            mem[midx(dm_addr, j)] = dm_write_data[8*j +: 8];
   end

   always @(negedge clk) begin
      txn_t t;
      if (dm_memread || dm_memwrite)
         chk("rd_wr_exclusive", {31'b0, dm_memread & dm_memwrite}, 32'd0);
      if (dm_memread) begin
         n_reads++;
         if (rd_q.size() == 0) chk("read_queue_level", rd_q.size(), 32'd1);
         else begin
            t = rd_q.pop_front();
            chk("rd_addr", dm_addr, t.addr);
            chk("rd_mask", {28'b0, dm_sign_mask}, {28'b0, t.mask});
         end
      end
      if (dm_memwrite) begin
         n_writes++;
         if (wr_q.size() == 0) chk("write_queue_level", wr_q.size(), 32'd1);
         else begin
            t = wr_q.pop_front();
            chk("wr_addr", dm_addr, t.addr);
            chk("wr_data", dm_write_data, t.data);
            chk("wr_mask", {28'b0, dm_sign_mask}, {28'b0, t.mask});
         end
      end
   end

   task automatic prep_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      ref_mem = mem;
      rd_q.delete();
      wr_q.delete();
      n_reads  = 0;
      n_writes = 0;
   endtask

   task automatic push_expect(input vec_t v, input int n_elem);
      int          inc;
      logic [3:0]  m;
      logic [31:0] sa, da, e;
      inc = (v.size == 2'b00) ? 1 : ((v.size == 2'b01) ? 2 : 4);
      m   = (v.size == 2'b00) ? 4'b0001 : ((v.size == 2'b01) ? 4'b0011 : 4'b0111);
      for (int i = 0; i < n_elem; i++) begin
         sa = v.src + 32'(i * inc);
         da = v.dst + 32'(i * inc);
         e  = '0;
         for (int j = 0; j < inc; j++)
            e[8*j +: 8] = v.fill ? v.fdata[8*j +: 8] : ref_mem[midx(sa, j)];
         if (!v.fill) rd_q.push_back('{sa, 32'h0, m});
         wr_q.push_back('{da, e, m});
      end
   endtask

   task automatic drive_start(input vec_t v);
      src_addr = v.src;
      dst_addr = v.dst;
      count    = CNT_W'(v.cnt);
      size     = v.size;
`ifdef DM_COPY_FILL_EN
      fill      = v.fill;
      fill_data = v.fdata;
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_addr = $urandom;
      dst_addr = $urandom;
      count    = CNT_W'($urandom);
   endtask

   task automatic run_vec(input vec_t v);
      int  inc, lat, busy_n, nb_tot;
      bit  got;
      logic [7:0] eb;
      inc = (v.size == 2'b00) ? 1 : ((v.size == 2'b01) ? 2 : 4);
      @(negedge clk);
      prep_mem();
      if (!v.exp_err) push_expect(v, v.cnt);
      drive_start(v);
      got = 0; lat = 0; busy_n = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            lat = k;
         end else if (busy) busy_n++;
      end
      chk("done_seen", {31'b0, got}, 32'd1);
      chk("done_latency", lat, v.exp_lat);
      chk("busy_cycles", busy_n, v.exp_lat);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      chk("err_at_done", {31'b0, err}, {31'b0, v.exp_err});
      chk("read_count", n_reads, v.exp_reads);
      chk("write_count", n_writes, v.exp_err ? 0 : v.cnt);
      chk("rd_queue_empty", rd_q.size(), 32'd0);
      chk("wr_queue_empty", wr_q.size(), 32'd0);
      nb_tot = v.exp_err ? 0 : v.cnt * inc;
      for (int b = 0; b < nb_tot; b++) begin
         eb = v.fill ? v.fdata[8*(b % inc) +: 8] : ref_mem[midx(v.src, b)];
         chk("mem_dst", {24'b0, mem[midx(v.dst, b)]}, {24'b0, eb});
      end
      chk("mem_below_dst", {24'b0, mem[midx(v.dst, -1)]}, {24'b0, ref_mem[midx(v.dst, -1)]});
      chk("mem_above_dst", {24'b0, mem[midx(v.dst, nb_tot)]},
          {24'b0, ref_mem[midx(v.dst, nb_tot)]});
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("busy_after_done", {31'b0, busy}, 32'd0);
      chk("err_sticky", {31'b0, err}, {31'b0, v.exp_err});
   endtask

   initial begin
      vec_t v;
      int   seen, lim;

      vecs.push_back('{32'h100, 32'h200, 3, 2'b10, 1'b0, 32'h0, 1'b0, 15, 3});
      vecs.push_back('{32'h101, 32'h203, 2, 2'b00, 1'b0, 32'h0, 1'b0, 10, 2});
      vecs.push_back('{32'h102, 32'h205, 2, 2'b01, 1'b0, 32'h0, 1'b1, 0, 0});
      vecs.push_back('{32'h100, 32'h200, 0, 2'b10, 1'b0, 32'h0, 1'b0, 0, 0});
      vecs.push_back('{32'h110, 32'h222, 3, 2'b01, 1'b0, 32'h0, 1'b0, 15, 3});
      vecs.push_back('{32'h100, 32'h200, 2, 2'b11, 1'b0, 32'h0, 1'b1, 0, 0});
      vecs.push_back('{32'h102, 32'h200, 1, 2'b10, 1'b0, 32'h0, 1'b1, 0, 0});
      vecs.push_back('{32'hFFFF_FFFC, 32'h400, 2, 2'b10, 1'b0, 32'h0, 1'b0, 10, 2});
      vecs.push_back('{32'h3FF, 32'h500, 1, 2'b00, 1'b0, 32'h0, 1'b0, 5, 1});
`ifdef DM_COPY_FILL_EN
      vecs.push_back('{32'h0, 32'h300, 4, 2'b10, 1'b1, 32'hDEAD_BEEF, 1'b0, 12, 0});
      vecs.push_back('{32'h7, 32'h351, 3, 2'b00, 1'b1, 32'h1234_5678, 1'b0, 9, 0});
      vecs.push_back('{32'h0, 32'h302, 1, 2'b10, 1'b1, 32'h1234_5678, 1'b1, 0, 0});
`endif

      // Reset state
      prep_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_memread", {31'b0, dm_memread}, 32'd0);
      chk("rst_memwrite", {31'b0, dm_memwrite}, 32'd0);
      chk("rst_addr", dm_addr, 32'd0);
      chk("rst_wdata", dm_write_data, 32'd0);
      chk("rst_sign_mask", {28'b0, dm_sign_mask}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Start held into the DONE cycle must not relaunch
      @(negedge clk);
      prep_mem();
      src_addr = 32'h100; dst_addr = 32'h200; count = '0; size = 2'b10;
`ifdef DM_COPY_FILL_EN
      fill = 1'b0;
`endif
      start = 1'b1;
      @(negedge clk);
      chk("zero_cnt_done", {31'b0, done}, 32'd1);
      @(posedge clk);
      #1 start = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("start_in_done_ignored", seen, 32'd0);

      // Second start while busy is ignored; reset in WR_WAIT of element 2 aborts
      @(negedge clk);
      prep_mem();
      v = '{32'h100, 32'h200, 4, 2'b10, 1'b0, 32'h0, 1'b0, 20, 4};
      push_expect(v, 2);
      drive_start(v);
      repeat (2) @(negedge clk);
      src_addr = 32'h500; dst_addr = 32'h600; count = CNT_W'(1); size = 2'b10;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lim = 0;
      while (n_writes < 2 && lim < 100) begin
         @(negedge clk);
         lim++;
      end
      chk("abort_second_write_seen", n_writes, 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_memwrite", {31'b0, dm_memwrite}, 32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_reads", n_reads, 32'd2);
      chk("abort_writes", n_writes, 32'd2);
      chk("abort_rd_queue", rd_q.size(), 32'd0);
      chk("abort_wr_queue", wr_q.size(), 32'd0);
      chk("abort_third_untouched", {24'b0, mem[12'h208]}, {24'b0, ref_mem[12'h208]});
      chk("ignored_copy_untouched", {24'b0, mem[12'h600]}, {24'b0, ref_mem[12'h600]});
      chk("abort_idle_busy", {31'b0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
